analysis_frame_scheduler: RTL and testbench
===========================================

// Module: analysis_frame_scheduler
// PURPOSE
//  Sequences the audio analysis datapath.
//  - Accepts codec samples and issues the read strobe shared by the codec and the DFT.
//  - After every DECIM accepted samples, waits SETTLE cycles for the DFT bins to settle,
//    then pulses the NoteFinder start.
//  - Tracks NoteFinder busy/done, counts dropped frames (overruns) and flags hung
//    NoteFinder cycles.
//  - Sits between audio_codec, DFT and NoteFinder; replaces the fixed read-delay start logic.
// PARAMETERS
//  SETTLE      4     cycles from a read strobe to the DFT bins being valid (>=1)
//  DECIM       16    accepted samples per NoteFinder cycle (>=1)
//  NF_TIMEOUT  4096  max cycles in WAIT_NF before forced return to IDLE (>=2)
//  CNT_W       16    width of sampleCount
// PORTS
//  clk           in   1      system clock (CLOCK_50 domain)
//  rst           in   1      asynchronous, active-low reset
//  enable        in   1      synchronous run enable; low = stop accepting samples
//  sampleReady   in   1      codec read_ready
//  doingRead     out  1      1-cycle read strobe to codec and DFT
//  nfStart       out  1      1-cycle NoteFinder startCycle pulse
//  nfDone        in   1      1-cycle NoteFinder completion pulse
//  nfBusy        out  1      high while NoteFinder FSM is in WAIT_NF
//  sampleCount   out  CNT_W  total accepted samples, wraps modulo 2^CNT_W
//  overrunCount  out  8      frames dropped because NoteFinder was busy; saturates at 255
//  timeoutFlag   out  1      sticky; set on NF_TIMEOUT expiry
// BEHAVIOUR
//  Reset (rst=0, async)
//  - All outputs go to 0, all counters to 0, NF FSM to IDLE, settle pipeline cleared.
//  - Reset takes effect mid-operation with no completion of pending work.
//  Read path (all outputs registered)
//  - At an edge where enable & sampleReady & ~doingRead, doingRead=1 for exactly one cycle
//    and sampleCount increments.
//  - Back-to-back reads are impossible; reads occur at most once every 2 cycles.
//  Decimation
//  - decCnt counts 0..DECIM-1 on each read.
//  - The read that wraps decCnt from DECIM-1 to 0 is the trigger read; it enters a
//    SETTLE-deep shift pipeline.
//  - Multiple triggers may be in flight in the pipeline.
//  Start
//  - A trigger read at cycle t reaches the pipeline tail at t+SETTLE.
//  - If the NF FSM is IDLE in that cycle, nfStart=1 at the next edge (1 cycle) and the
//    FSM enters WAIT_NF.
//  - If the FSM is in WAIT_NF, nfStart stays 0, the frame is dropped and overrunCount
//    increments (saturating at 255).
//  NF FSM
//  - IDLE -> WAIT_NF on nfStart issue.
//  - WAIT_NF -> IDLE on nfDone.
//  - WAIT_NF -> IDLE when the WAIT_NF cycle counter reaches NF_TIMEOUT; timeoutFlag set.
//  - nfBusy = (state == WAIT_NF).
//  - nfDone while IDLE is ignored.
//  Simultaneous events
//  - nfDone in the same cycle a trigger reaches the pipeline tail: treated as IDLE.
//    nfStart is issued, no overrun, and the FSM stays in WAIT_NF with its timer
//    restarted at 0.
//  - Timeout expiry coinciding with a trigger behaves the same way, and timeoutFlag
//    is still set.
//  enable low
//  - No new reads; decCnt cleared to 0; settle pipeline flushed (pending triggers dropped
//    silently, no overrun).
//  - The NF FSM continues to nfDone or timeout.
//  - timeoutFlag and overrunCount clear on the edge where enable is low; sampleCount is
//    held.
//  Widths
//  - sampleCount wraps without a flag.
//  - The WAIT_NF timer is $clog2(NF_TIMEOUT+1) bits.
// TESTING
//  1. Reset: rst=0 asynchronously mid-WAIT_NF with pipeline loaded -> all outputs 0
//     immediately; after release, first read is counted as sampleCount=1.
//  2. Cadence, DECIM=16, SETTLE=4: sampleReady held high with nfDone echoed 10 cycles after
//     each nfStart -> doingRead every 2nd cycle; nfStart 4 cycles after every 16th read;
//     sampleCount=64 after 4 starts; overrunCount=0.
//  3. Overrun: hold nfDone low for 3 trigger intervals -> exactly 1 nfStart,
//     overrunCount=2, nfBusy=1 throughout.
//  4. Timeout, NF_TIMEOUT=100: nfDone never asserted -> nfBusy drops exactly 100 cycles
//     after entry to WAIT_NF; timeoutFlag=1; the next trigger issues nfStart.
//  5. Coincidence: nfDone on the same cycle a trigger reaches the tail -> nfStart=1 next
//     cycle, overrunCount unchanged, nfBusy stays 1.
//  6. enable drop: enable=0 one cycle after a trigger read -> no nfStart, no overrun,
//     decCnt restarts so the next trigger is the 16th read after re-enable;
//     sampleCount=0xFFFF +1 -> 0x0000.

Source files
------------

// File: rtl/analysis_frame_scheduler_if.sv
// Handshake bundle between the frame scheduler and the codec / DFT / NoteFinder side.
// The scheduler connects to the slave modport; the driving side uses master.
interface analysis_frame_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             sampleReady;
    logic             doingRead;
    logic             nfStart;
    logic             nfDone;
    logic             nfBusy;
    logic [CNT_W-1:0] sampleCount;
    logic [7:0]       overrunCount;
    logic             timeoutFlag;

    modport master (
        output enable, sampleReady, nfDone,
        input  doingRead, nfStart, nfBusy, sampleCount, overrunCount, timeoutFlag
    );

    modport slave (
        input  enable, sampleReady, nfDone,
        output doingRead, nfStart, nfBusy, sampleCount, overrunCount, timeoutFlag
    );
endinterface

// File: rtl/analysis_frame_scheduler.sv
// Audio analysis sequencer: issues codec/DFT read strobes, decimates them into frames,
// and starts NoteFinder SETTLE cycles after each frame trigger, with overrun and hang tracking.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | NoteFinder free; the next trigger at the pipeline tail starts it
// WAIT_NF | NoteFinder running; leave on nfDone or when the timer expires
module analysis_frame_scheduler #(
    parameter int SETTLE     = 4,
    parameter int DECIM      = 16,
    parameter int NF_TIMEOUT = 4096,
    parameter int CNT_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    analysis_frame_scheduler_if.slave   bus
);

    localparam int TMR_W = $clog2(NF_TIMEOUT + 1);
    localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    typedef enum logic {
        IDLE    = 1'b0,
        WAIT_NF = 1'b1
    } nf_state_t;

    nf_state_t          state_q, state_d;
    logic               doing_read_q, doing_read_d;
    logic [CNT_W-1:0]   sample_count_q, sample_count_d;
    logic [DEC_W-1:0]   dec_cnt_q, dec_cnt_d;
    logic [SETTLE-1:0]  settle_pipe_q, settle_pipe_d;
    logic [TMR_W-1:0]   nf_tmr_q, nf_tmr_d;
    logic               nf_start_q, nf_start_d;
    logic [7:0]         overrun_q, overrun_d;
    logic               timeout_q, timeout_d;

    logic read_go;
    logic trig;
    logic tail;
    logic nf_done;
    logic nf_expire;
    logic nf_free;

    always_comb begin
        state_d        = state_q;
        doing_read_d   = 1'b0;
        sample_count_d = sample_count_q;
        dec_cnt_d      = dec_cnt_q;
        settle_pipe_d  = settle_pipe_q;
        nf_tmr_d       = nf_tmr_q;
        nf_start_d     = 1'b0;
        overrun_d      = overrun_q;
        timeout_d      = timeout_q;

        read_go   = bus.enable & bus.sampleReady & ~doing_read_q;
        trig      = read_go && (dec_cnt_q == DEC_W'(DECIM - 1));
        tail      = settle_pipe_q[SETTLE-1] & bus.enable;
        nf_done   = (state_q == WAIT_NF) && bus.nfDone;
        nf_expire = (state_q == WAIT_NF) && (nf_tmr_q == '0);
        nf_free   = (state_q == IDLE) || nf_done || nf_expire;

        doing_read_d = read_go;
        if (read_go) begin
            sample_count_d = sample_count_q + 1'b1;
            dec_cnt_d      = trig ? '0 : dec_cnt_q + 1'b1;
        end

        // Stage 0 loads alongside the read strobe, so the start lands SETTLE cycles after it.
        settle_pipe_d[0] = trig;
        for (int i = 1; i < SETTLE; i++) begin
            settle_pipe_d[i] = settle_pipe_q[i-1];
        end

        if (state_q == WAIT_NF) begin
            if (nf_done || nf_expire) begin
                state_d = IDLE;
            end else begin
                nf_tmr_d = nf_tmr_q - 1'b1;
            end
        end

        // A completion or expiry in the same cycle as a trigger frees the slot for it.
        if (tail) begin
            if (nf_free) begin
                nf_start_d = 1'b1;
                state_d    = WAIT_NF;
                nf_tmr_d   = TMR_W'(NF_TIMEOUT - 1);
            end else if (overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
            end
        end

        if (nf_expire) begin
            timeout_d = 1'b1;
        end

        if (!bus.enable) begin
            dec_cnt_d     = '0;
            settle_pipe_d = '0;
            overrun_d     = '0;
            timeout_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            doing_read_q   <= 1'b0;
            sample_count_q <= '0;
            dec_cnt_q      <= '0;
            settle_pipe_q  <= '0;
            nf_tmr_q       <= '0;
            nf_start_q     <= 1'b0;
            overrun_q      <= '0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            doing_read_q   <= doing_read_d;
            sample_count_q <= sample_count_d;
            dec_cnt_q      <= dec_cnt_d;
            settle_pipe_q  <= settle_pipe_d;
            nf_tmr_q       <= nf_tmr_d;
            nf_start_q     <= nf_start_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    assign bus.doingRead    = doing_read_q;
    assign bus.nfStart      = nf_start_q;
    assign bus.nfBusy       = (state_q == WAIT_NF);
    assign bus.sampleCount  = sample_count_q;
    assign bus.overrunCount = overrun_q;
    assign bus.timeoutFlag  = timeout_q;

endmodule

// File: tb/tb_analysis_frame_scheduler.sv
// Randomized bench for analysis_frame_scheduler against an event-time reference model.
// The model tracks pending starts as absolute due cycles and NoteFinder hangs by entry time.
module tb_analysis_frame_scheduler;

    localparam int SETTLE     = 4;
    localparam int DECIM      = 16;
    localparam int NF_TIMEOUT = 100;
    localparam int CNT_W      = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;

    analysis_frame_scheduler_if #(.CNT_W(CNT_W)) bus ();

    analysis_frame_scheduler #(
        .SETTLE     (SETTLE),
        .DECIM      (DECIM),
        .NF_TIMEOUT (NF_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // reference model state
    int cyc;
    bit m_read, m_start, m_busy, m_tflag;
    int m_count, m_dec, m_ovr, m_entry;
    int due_q[$];

    // stimulus knobs
    int en_pct, sr_pct, done_mode, done_delay, done_pct;
    int since_start;

    function automatic void model_reset();
        cyc         = 0;
        m_read      = 0;
        m_start     = 0;
        m_busy      = 0;
        m_tflag     = 0;
        m_count     = 0;
        m_dec       = 0;
        m_ovr       = 0;
        m_entry     = 0;
        since_start = 100000;
        due_q.delete();
    endfunction

    function automatic void model_edge();
        bit en, sr, dn, rd, tail, done, tout;
        en   = bus.enable;
        sr   = bus.sampleReady;
        dn   = bus.nfDone;
        rd   = en && sr && !m_read;
        tail = 0;
        cyc++;
        done = m_busy && dn;
        tout = m_busy && ((cyc - m_entry) == NF_TIMEOUT);
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            void'(due_q.pop_front());
            tail = en;
        end
        m_start = 0;
        if (done || tout) m_busy = 0;
        if (tout) m_tflag = 1;
        if (tail) begin
            if (!m_busy) begin
                m_start = 1;
                m_busy  = 1;
                m_entry = cyc;
            end else if (m_ovr < 255) begin
                m_ovr++;
            end
        end
        if (rd) begin
            m_count = (m_count + 1) % (1 << CNT_W);
            m_dec++;
            if (m_dec == DECIM) begin
                m_dec = 0;
                due_q.push_back(cyc + SETTLE);
            end
        end
        m_read = rd;
        if (!en) begin
            m_dec = 0;
            due_q.delete();
            m_ovr   = 0;
            m_tflag = 0;
        end
        if (m_start) since_start = 0;
        else if (since_start < 100000) since_start++;
    endfunction

    task automatic compare_all();
        check_val("doingRead",    32'(bus.doingRead),    32'(m_read));
        check_val("nfStart",      32'(bus.nfStart),      32'(m_start));
        check_val("nfBusy",       32'(bus.nfBusy),       32'(m_busy));
        check_val("sampleCount",  32'(bus.sampleCount),  32'(m_count));
        check_val("overrunCount", 32'(bus.overrunCount), 32'(m_ovr));
        check_val("timeoutFlag",  32'(bus.timeoutFlag),  32'(m_tflag));
    endtask

    task automatic drive_inputs();
        bus.enable      = ($urandom_range(99) < en_pct);
        bus.sampleReady = ($urandom_range(99) < sr_pct);
        case (done_mode)
            1:       bus.nfDone = (since_start == done_delay - 1);
            2:       bus.nfDone = ($urandom_range(99) < done_pct);
            default: bus.nfDone = 1'b0;
        endcase
    endtask

    task automatic run(input int n);
        repeat (n) begin
            drive_inputs();
            @(posedge clk);
            model_edge();
            @(negedge clk);
            compare_all();
        end
    endtask

    task automatic set_mode(input int en, input int sr, input int dm, input int dd, input int dp);
        en_pct     = en;
        sr_pct     = sr;
        done_mode  = dm;
        done_delay = dd;
        done_pct   = dp;
    endtask

    // Called on a falling edge; asserts reset between edges and checks outputs clear at once.
    task automatic do_reset();
        #2 rst = 1'b0;
        #1;
        check_val("rst_doingRead",    32'(bus.doingRead),    32'd0);
        check_val("rst_nfStart",      32'(bus.nfStart),      32'd0);
        check_val("rst_nfBusy",       32'(bus.nfBusy),       32'd0);
        check_val("rst_sampleCount",  32'(bus.sampleCount),  32'd0);
        check_val("rst_overrunCount", 32'(bus.overrunCount), 32'd0);
        check_val("rst_timeoutFlag",  32'(bus.timeoutFlag),  32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int guard;
        bus.enable      = 1'b0;
        bus.sampleReady = 1'b0;
        bus.nfDone      = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // steady cadence with NoteFinder answering 10 cycles after each start
        set_mode(100, 100, 1, 10, 0);
        run(300);

        // NoteFinder completes exactly when the next trigger reaches the tail
        set_mode(100, 100, 1, 32, 0);
        run(300);

        // NoteFinder never answers: timeouts, overruns up to saturation, counter wrap
        set_mode(100, 100, 0, 0, 0);
        run(12000);

        // enable toggling with sporadic completions
        set_mode(92, 70, 2, 0, 5);
        run(3000);

        // load the pipeline during WAIT_NF, then reset asynchronously
        set_mode(100, 100, 0, 0, 0);
        guard = 0;
        while (!(m_busy && due_q.size() > 0) && guard < 500) begin
            run(1);
            guard++;
        end
        check_val("reset_setup_reached", 32'(guard < 500), 32'd1);
        do_reset();

        // fully random traffic
        set_mode(97, 60, 2, 0, 3);
        run(5000);
        set_mode(99, 100, 2, 0, 1);
        run(5000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
